// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - RV32 ALU control decode with 2-entry skid-buffered issue
module alu_ctrl_issue #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [2:0]        ALUCtrl_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic              illegal_o,
    output logic [15:0]       issue_cnt_o
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_rs1_field;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    // Register indices are resolved upstream; only their data arrives here.
    assign unused_rs1_field = ^instr_i[19:15];

    logic [2:0]        dec_ctrl;
    logic [DATA_W-1:0] dec_d1;
    logic [DATA_W-1:0] dec_d2;
    logic              dec_ill;

    // Decode the incoming instruction into ALU opcode and operands.
    always_comb begin
        dec_ctrl = ALU_ADD;
        dec_d1   = rs1_data_i;
        dec_d2   = rs2_data_i;
        dec_ill  = 1'b0;
        case (opcode)
            OP_REG: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_ctrl = ALU_ADD;
                        3'b001:  dec_ctrl = ALU_SLL;
                        3'b100:  dec_ctrl = ALU_XOR;
                        3'b111:  dec_ctrl = ALU_AND;
                        default: dec_ill  = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_ctrl = ALU_SUB;
                end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
                    dec_ctrl = ALU_MUL;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    dec_ctrl = ALU_ADD;
                    dec_d2   = {{20{instr_i[31]}}, instr_i[31:20]};
                end else if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
                    dec_ctrl = ALU_SRA;
                    dec_d2   = {27'b0, instr_i[24:20]};
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OP_LOAD: begin
                dec_ctrl = ALU_ADD;
                dec_d2   = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_STORE: begin
                dec_ctrl = ALU_ADD;
                dec_d2   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                dec_ctrl = ALU_SUB;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_ctrl = ALU_ADD;
            dec_d1   = '0;
            dec_d2   = '0;
        end
    end

    logic              main_valid_q, main_valid_d;
    logic [2:0]        main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_d1_q,    main_d1_d;
    logic [DATA_W-1:0] main_d2_q,    main_d2_d;
    logic              main_ill_q,   main_ill_d;
    logic              skid_valid_q, skid_valid_d;
    logic [2:0]        skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_d1_q,    skid_d1_d;
    logic [DATA_W-1:0] skid_d2_q,    skid_d2_d;
    logic              skid_ill_q,   skid_ill_d;
    logic [15:0]       cnt_q,        cnt_d;

    logic accept;
    logic issue;

    assign in_ready_o  = !skid_valid_q;
    assign accept      = in_valid_i & in_ready_o;
    assign issue       = main_valid_q & out_ready_i;

    assign out_valid_o = main_valid_q;
    assign ALUCtrl_o   = main_ctrl_q;
    assign data1_o     = main_d1_q;
    assign data2_o     = main_d2_q;
    assign illegal_o   = main_ill_q;
    assign issue_cnt_o = cnt_q;

    // Skid-buffer next state: refill main from skid first, then from input.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_d1_d    = main_d1_q;
        main_d2_d    = main_d2_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_d1_d    = skid_d1_q;
        skid_d2_d    = skid_d2_q;
        skid_ill_d   = skid_ill_q;
        cnt_d        = cnt_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (issue) begin
                cnt_d = cnt_q + 16'd1;
            end
            if (!main_valid_q || issue) begin
                if (skid_valid_q) begin
                    // in_ready_o is low here, so no new op competes for main.
                    main_valid_d = 1'b1;
                    main_ctrl_d  = skid_ctrl_q;
                    main_d1_d    = skid_d1_q;
                    main_d2_d    = skid_d2_q;
                    main_ill_d   = skid_ill_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = dec_ctrl;
                    main_d1_d    = dec_d1;
                    main_d2_d    = dec_d2;
                    main_ill_d   = dec_ill;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = dec_ctrl;
                skid_d1_d    = dec_d1;
                skid_d2_d    = dec_d2;
                skid_ill_d   = dec_ill;
            end
        end
    end

    // State registers; reset clears valids, payloads and the issue counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= ALU_ADD;
            main_d1_q    <= '0;
            main_d2_q    <= '0;
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= ALU_ADD;
            skid_d1_q    <= '0;
            skid_d2_q    <= '0;
            skid_ill_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_d1_q    <= main_d1_d;
            main_d2_q    <= main_d2_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_d1_q    <= skid_d1_d;
            skid_d2_q    <= skid_d2_d;
            skid_ill_q   <= skid_ill_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb/tb_alu_ctrl_issue.sv - table-driven and sequence checks for alu_ctrl_issue
module tb_alu_ctrl_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  ALUCtrl_o;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic        illegal_o;
    logic [15:0] issue_cnt_o;

    int checks = 0;
    int errors = 0;

    alu_ctrl_issue #(.DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .ALUCtrl_o   (ALUCtrl_o),
        .data1_o     (data1_o),
        .data2_o     (data2_o),
        .illegal_o   (illegal_o),
        .issue_cnt_o (issue_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        ill;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        instr_i = 32'h0; rs1_data_i = 32'h0; rs2_data_i = 32'h0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, {31'b0, out_valid_o}, 32'd0);
        chk({tag, "_in_ready"},  {31'b0, in_ready_o},  32'd1);
        chk({tag, "_ctrl"},      {29'b0, ALUCtrl_o},   32'd0);
        chk({tag, "_d1"},        data1_o,              32'd0);
        chk({tag, "_d2"},        data2_o,              32'd0);
        chk({tag, "_illegal"},   {31'b0, illegal_o},   32'd0);
        chk({tag, "_cnt"},       {16'b0, issue_cnt_o}, 32'd0);
    endtask

    // Present an ADD with a tag value in rs1 (at a negedge, caller-managed).
    task automatic drive_add(input logic [31:0] tag);
        in_valid_i = 1'b1;
        instr_i    = 32'h0000_0033;
        rs1_data_i = tag;
        rs2_data_i = 32'h0;
    endtask

    initial begin
        vecs[0]  = '{32'h4000_0033, 32'd7,         32'd3,         3'b110, 32'd7,         32'd3,         1'b0}; // SUB
        vecs[1]  = '{32'h0000_0033, 32'h1111_0000, 32'h0000_2222, 3'b000, 32'h1111_0000, 32'h0000_2222, 1'b0}; // ADD
        vecs[2]  = '{32'h0000_1033, 32'hA5A5_A5A5, 32'd9,         3'b001, 32'hA5A5_A5A5, 32'd9,         1'b0}; // SLL
        vecs[3]  = '{32'h0000_4033, 32'hFFFF_0000, 32'h00FF_00FF, 3'b100, 32'hFFFF_0000, 32'h00FF_00FF, 1'b0}; // XOR
        vecs[4]  = '{32'h0000_7033, 32'h1234_5678, 32'h8765_4321, 3'b111, 32'h1234_5678, 32'h8765_4321, 1'b0}; // AND
        vecs[5]  = '{32'h0200_0033, 32'd12,        32'd13,        3'b010, 32'd12,        32'd13,        1'b0}; // MUL
        vecs[6]  = '{32'hFFF0_0013, 32'd5,         32'hDEAD_BEEF, 3'b000, 32'd5,         32'hFFFF_FFFF, 1'b0}; // ADDI -1
        vecs[7]  = '{32'h1230_0013, 32'd100,       32'hDEAD_BEEF, 3'b000, 32'd100,       32'h0000_0123, 1'b0}; // ADDI 0x123
        vecs[8]  = '{32'h4040_5013, 32'h8000_0000, 32'hDEAD_BEEF, 3'b101, 32'h8000_0000, 32'd4,         1'b0}; // SRAI 4
        vecs[9]  = '{32'hFFC0_2003, 32'h0000_1000, 32'h5555_5555, 3'b000, 32'h0000_1000, 32'hFFFF_FFFC, 1'b0}; // LW -4
        vecs[10] = '{32'h8400_22A3, 32'h0000_2000, 32'h6666_6666, 3'b000, 32'h0000_2000, 32'hFFFF_F845, 1'b0}; // SW 0x845
        vecs[11] = '{32'h0000_0063, 32'd42,        32'd41,        3'b110, 32'd42,        32'd41,        1'b0}; // BEQ
        vecs[12] = '{32'h0000_007F, 32'h1357_9BDF, 32'h2468_ACE0, 3'b000, 32'd0,         32'd0,         1'b1}; // opcode 1111111
        vecs[13] = '{32'h0000_1013, 32'd1,         32'd2,         3'b000, 32'd0,         32'd0,         1'b1}; // SLLI not supported
        vecs[14] = '{32'h0000_2033, 32'd3,         32'd4,         3'b000, 32'd0,         32'd0,         1'b1}; // SLT not supported

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        instr_i = 32'h0; rs1_data_i = 32'h0; rs2_data_i = 32'h0;

        // Reset values
        do_reset();
        @(negedge clk_i);
        check_reset_state("reset");

        // Table-driven decode: each op visible one cycle after accept, then issued
        out_ready_i = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid_i = 1'b1;
            instr_i    = vecs[i].instr;
            rs1_data_i = vecs[i].rs1;
            rs2_data_i = vecs[i].rs2;
            @(negedge clk_i);
            in_valid_i = 1'b0;
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid_o}, 32'd1);
            chk($sformatf("vec%0d_ctrl", i),  {29'b0, ALUCtrl_o},   {29'b0, vecs[i].ctrl});
            chk($sformatf("vec%0d_d1", i),    data1_o,              vecs[i].d1);
            chk($sformatf("vec%0d_d2", i),    data2_o,              vecs[i].d2);
            chk($sformatf("vec%0d_ill", i),   {31'b0, illegal_o},   {31'b0, vecs[i].ill});
            chk($sformatf("vec%0d_cnt", i),   {16'b0, issue_cnt_o}, i);
            @(negedge clk_i);
            chk($sformatf("vec%0d_drained", i), {31'b0, out_valid_o}, 32'd0);
        end
        chk("table_cnt", {16'b0, issue_cnt_o}, NV);

        // Stall: A, B, C back-to-back with out_ready low
        do_reset();
        out_ready_i = 1'b0;
        drive_add(32'hA);
        @(negedge clk_i);
        drive_add(32'hB);
        @(negedge clk_i);
        drive_add(32'hC);
        chk("stall_in_ready", {31'b0, in_ready_o}, 32'd0);
        chk("stall_head_A",   data1_o, 32'hA);
        repeat (3) @(negedge clk_i);
        chk("stall_hold_valid", {31'b0, out_valid_o}, 32'd1);
        chk("stall_hold_A",     data1_o, 32'hA);
        chk("stall_hold_ready", {31'b0, in_ready_o}, 32'd0);
        chk("stall_hold_cnt",   {16'b0, issue_cnt_o}, 32'd0);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        chk("drain_B",       data1_o, 32'hB);
        chk("drain_B_ready", {31'b0, in_ready_o}, 32'd1);
        chk("drain_B_cnt",   {16'b0, issue_cnt_o}, 32'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("drain_C",       data1_o, 32'hC);
        chk("drain_C_valid", {31'b0, out_valid_o}, 32'd1);
        @(negedge clk_i);
        chk("drain_empty", {31'b0, out_valid_o}, 32'd0);
        chk("drain_cnt",   {16'b0, issue_cnt_o}, 32'd3);

        // Flush with both entries full and a new op offered
        do_reset();
        out_ready_i = 1'b0;
        drive_add(32'h1);
        @(negedge clk_i);
        drive_add(32'h2);
        @(negedge clk_i);
        chk("flush_pre_ready", {31'b0, in_ready_o}, 32'd0);
        drive_add(32'h3);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_valid", {31'b0, out_valid_o}, 32'd0);
        chk("flush_ready", {31'b0, in_ready_o},  32'd1);
        chk("flush_cnt",   {16'b0, issue_cnt_o}, 32'd0);

        // Flush overrides an accept into an empty buffer, and a same-cycle issue
        out_ready_i = 1'b1;
        drive_add(32'h4);
        @(negedge clk_i);
        drive_add(32'h5);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_acc_valid", {31'b0, out_valid_o}, 32'd0);
        chk("flush_acc_cnt",   {16'b0, issue_cnt_o}, 32'd0);

        // Reset mid-stall with both entries full
        out_ready_i = 1'b0;
        drive_add(32'h6);
        @(negedge clk_i);
        drive_add(32'h7);
        @(negedge clk_i);
        instr_i = 32'h0000_007F;
        @(negedge clk_i);
        rst_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk_i);
        check_reset_state("midrst");
        rst_i = 1'b0;
        flush_i = 1'b0;
        in_valid_i = 1'b0;

        // Counter wrap: stream until 0xFFFF, next issue wraps to zero
        do_reset();
        out_ready_i = 1'b1;
        drive_add(32'h9);
        begin
            int n;
            n = 0;
            while (issue_cnt_o != 16'hFFFF && n < 70000) begin
                @(negedge clk_i);
                n++;
            end
            chk("wrap_reached", {16'b0, issue_cnt_o}, 32'h0000_FFFF);
        end
        chk("wrap_valid", {31'b0, out_valid_o}, 32'd1);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("wrap_zero", {16'b0, issue_cnt_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
